// File: rtl/sub_bytes_engine_pkg.sv
// sub_bytes_engine_pkg: FSM encoding, S-box constants and GF(2^8) helpers
package sub_bytes_engine_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic [7:0] GF_POLY      = 8'h1b;
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ AFFINE_C;
  endfunction
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ INV_AFFINE_C;
  endfunction
endpackage

// File: rtl/sub_bytes_engine_sbox.sv
// sbox_byte_dual: combinational AES S-box, forward or inverse selected by dec
module sbox_byte_dual
  import sub_bytes_engine_pkg::*;
(
  input  logic [7:0] in,
  output logic [7:0] out,
  input  logic       dec
);
  assign out = dec ? gf_inv(inv_affine(in)) : affine(gf_inv(in));
endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: folded SubBytes/InvSubBytes engine, NSBOX bytes per cycle
module sub_bytes_engine
  import sub_bytes_engine_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int NSBOX  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                in_dec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                out_dec,
  output logic                busy
);
  localparam int F  = NBYTES / NSBOX;
  localparam int CW = (F > 1) ? $clog2(F) : 1;
  localparam logic [CW-1:0] LAST = CW'(F - 1);
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [8*NBYTES-1:0]   r_data;
  logic                  r_dec;
  logic [NSBOX-1:0][7:0] w_sel;
  logic [NSBOX-1:0][7:0] w_sub;
  logic [8*NBYTES-1:0]   w_next;
  logic                  w_accept;
  logic                  w_last;
  if (!(NBYTES == 4 || NBYTES == 12 || NBYTES == 16) || (NBYTES % NSBOX) != 0) begin : g_bad_cfg
    $error("sub_bytes_engine: illegal NBYTES/NSBOX combination");
  end
  assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = r_cnt == LAST;
  assign out_valid = r_state == ST_DONE;
  assign busy      = r_state != ST_IDLE;
  assign out_data  = r_data;
  assign out_dec   = r_dec;
  // byte 0 sits in the MSBs, so chunk c covers bytes c*NSBOX.. counted from the top
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < F; c++)
      for (int k = 0; k < NSBOX; k++)
        if (r_cnt == CW'(c)) w_sel[k] = r_data[8*(NBYTES-1-c*NSBOX-k) +: 8];
  end
  always_comb begin
    w_next = r_data;
    for (int c = 0; c < F; c++)
      for (int k = 0; k < NSBOX; k++)
        if (r_cnt == CW'(c)) w_next[8*(NBYTES-1-c*NSBOX-k) +: 8] = w_sub[k];
  end
  for (genvar g = 0; g < NSBOX; g++) begin : g_sbox
    sbox_byte_dual u_sbox (
      .in  (w_sel[g]),
      .out (w_sub[g]),
      .dec (r_dec)
    );
  end
  // abort outranks accept and consume; DONE with a waiting word chains straight into RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_dec   <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_data  <= in_data;
      r_dec   <= in_dec;
    end else if (r_state == ST_RUN) begin
      r_data  <= w_next;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      r_state <= w_last ? ST_DONE : ST_RUN;
    end else if (r_state == ST_DONE && out_ready) begin
      r_state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: directed vectors for the 16/4 and 4/4 configurations
module tb_sub_bytes_engine;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         abort, in_valid, in_ready, in_dec, out_valid, out_ready, out_dec, busy;
  logic [127:0] in_data, out_data;
  logic         s_in_valid, s_in_ready, s_in_dec, s_out_valid, s_out_dec, s_busy;
  logic [31:0]  s_in_data, s_out_data;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           pulses;
  localparam logic [127:0] V_PLAIN = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V_SUB   = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] V_53    = {16{8'h53}};
  localparam logic [127:0] V_ED    = {16{8'hed}};
  localparam logic [127:0] V_01    = {16{8'h01}};
  localparam logic [127:0] V_7C    = {16{8'h7c}};
  always #5 clk = ~clk;
  sub_bytes_engine #(.NBYTES(16), .NSBOX(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dec(in_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dec(out_dec),
    .busy(busy)
  );
  sub_bytes_engine #(.NBYTES(4), .NSBOX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .abort(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_dec(s_in_dec),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data), .out_dec(s_out_dec),
    .busy(s_busy)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [127:0] d, input logic m);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_dec   = m;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_dec   = ~m;
  endtask
  task automatic wait_res(input string tag, input logic [127:0] d, input logic m);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'd4);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_dec"}, 128'(out_dec), 128'(m));
  endtask
  task automatic run4(input string tag, input logic [31:0] d, input logic m, input logic [31:0] exp);
    int lat = 0;
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_data  = d;
    s_in_dec   = m;
    @(negedge clk);
    s_in_valid = 1'b0;
    s_in_data  = ~d;
    s_in_dec   = ~m;
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'd1);
    chk({tag, "_data"}, 128'(s_out_data), 128'(exp));
    chk({tag, "_dec"}, 128'(s_out_dec), 128'(m));
  endtask
  task automatic no_pulse(input string tag);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk(tag, 128'(pulses), 128'd0);
  endtask
  initial begin
    rst_n = 1'b1;
    {abort, in_valid, in_dec, s_in_valid, s_in_dec} = '0;
    out_ready = 1'b1;
    in_data = '0;
    s_in_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ov", 128'(out_valid), 128'd0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_dec", 128'(out_dec), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst4_ov", 128'(s_out_valid), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(V_PLAIN, 1'b0);
    wait_res("fwd16", V_SUB, 1'b0);
    send(V_SUB, 1'b1);
    wait_res("inv16", V_PLAIN, 1'b1);
    run4("fwd4", 32'h00530001, 1'b0, 32'h63ed637c);
    run4("inv4", 32'h63ed637c, 1'b1, 32'h00530001);
    out_ready = 1'b0;
    send(V_53, 1'b0);
    wait_res("hold", V_ED, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_data", out_data, V_ED);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = V_01;
    in_dec    = 1'b0;
    #1 chk("chain_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    chk("chain_busy", 128'(busy), 128'd1);
    chk("chain_ov", 128'(out_valid), 128'd0);
    in_valid = 1'b0;
    wait_res("chain", V_7C, 1'b0);
    send(V_PLAIN, 1'b0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_ov", 128'(out_valid), 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    no_pulse("abort_pulses");
    send(V_PLAIN, 1'b0);
    wait_res("post_abort", V_SUB, 1'b0);
    send(V_SUB, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 128'(busy), 128'd0);
    chk("rst_mid_ov", 128'(out_valid), 128'd0);
    chk("rst_mid_data", out_data, 128'd0);
    chk("rst_mid_dec", 128'(out_dec), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_pulse("rst_pulses");
    send(V_SUB, 1'b1);
    wait_res("post_rst", V_PLAIN, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 The block SHALL have parameter NBYTES, default 16, giving the number of bytes per word; legal values are 4, 12 and 16.
REQ-002 The block SHALL have parameter NSBOX, default 4, giving the number of S-box instances; it must divide NBYTES, and the fold factor is F = NBYTES/NSBOX.
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 abort  input  1  synchronous flush; discards any word in flight.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block can accept an input word.
REQ-008 in_data  input  8*NBYTES  input word; byte 0 occupies the MSBs.
REQ-009 in_dec  input  1  mode select: 0 = forward S-box, 1 = inverse S-box.
REQ-010 out_valid  output  1  result word present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  8*NBYTES  substituted word, in the same byte order as in_data.
REQ-013 out_dec  output  1  mode with which out_data was produced.
REQ-014 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-016 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready).
REQ-017 On an accept (in_valid & in_ready), the block SHALL capture in_data and in_dec, clear the chunk counter cnt to 0 and enter RUN.
REQ-018 In RUN, each cycle SHALL replace bytes cnt*NSBOX .. cnt*NSBOX+NSBOX-1 of the working register with their S-box values and then increment cnt.
REQ-019 When a RUN cycle processes cnt==F-1, the FSM SHALL go to DONE on that edge; cnt is ceil(log2 F) bits wide, minimum 1 bit.
REQ-020 Forward mode SHALL compute affine(GF(2^8)-inverse(x)) with affine constant 0x63; inverse mode SHALL compute GF-inverse(inverse-affine(x)) with constant 0x05; the inverse of 0x00 is defined as 0x00.
REQ-021 out_valid SHALL be high exactly in DONE, and out_data and out_dec SHALL be held stable while out_valid & !out_ready.
REQ-022 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE.
REQ-023 In DONE with out_ready=1 and in_valid=1, the result SHALL be consumed and the new word accepted on the same edge, going directly to RUN.
REQ-024 Latency SHALL be F cycles: accept at edge k gives out_valid high after edge k+F.
REQ-025 Sustained throughput SHALL be one word per F cycles when out_ready is held high.
REQ-026 Changes on in_dec or in_data after the accept SHALL have no effect on the word in flight.
REQ-027 With F==1, RUN SHALL last exactly one cycle.
REQ-028 abort=1 SHALL force IDLE and cnt=0 and drop out_valid on the next edge; abort has priority over an accept or consume in the same cycle.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, cnt=0, out_valid=0, busy=0, out_data=0 and out_dec=0; in_ready=1 follows from IDLE.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the word; no partial result is ever presented.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, AFFINE_C=8'h63, INV_AFFINE_C=8'h05 and the GF(2^8) inverse table function.
REQ-032 There SHALL be one sub-module, sbox_byte_dual: a combinational 8-bit dual-mode S-box with ports in, out and dec, instantiated NSBOX times.
REQ-033 Byte selection into the S-box instances SHALL be a cnt-indexed multiplexer; no NBYTES-wide S-box array is permitted when NSBOX<NBYTES.

Verification
REQ-034 NBYTES=16, NSBOX=4, forward mode, in_data=000102030405060708090a0b0c0d0e0f -> out_data=637c777bf26b6fc53001672bfed7ab76, with out_valid 4 cycles after the accept.
REQ-035 Same configuration, inverse mode, in_data=637c777bf26b6fc53001672bfed7ab76 -> 000102030405060708090a0b0c0d0e0f, out_dec=1.
REQ-036 NBYTES=4, NSBOX=4, forward mode, in_data=0053_0001 (bytes 00 53 00 01) -> 63ED637C, latency 1; then inverse of 63ED637C -> 00530001.
REQ-037 Hold out_ready=0 for 5 cycles in DONE: out_data stable, in_ready=0; then assert out_ready with in_valid=1 -> consume and new accept on the same edge, FSM in RUN.
REQ-038 Assert abort at cnt=2, and separately assert rst_n=0 mid-RUN: FSM returns to IDLE, no out_valid pulse, and the next word produces a correct result.
